// File: rtl/ones_count_pkg.sv
// Shared types and constants for the byte-serial ones counter.
package ones_count_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/ones_count_ctrl_serial1s.sv
// Combinational 8-bit population count, time-shared by the controller across bytes.
module serial1s (
    input  logic [7:0] din,
    output logic [3:0] count
);

    always_comb begin
        // NOTE: blocking assignments are required here because each iteration
        // must see the partial sum left by the previous one.
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, din[i]};
        end
    end

endmodule

// File: rtl/ones_count_ctrl.sv
// Byte-serial ones counter with valid/ready handshakes on both sides.
// Optional macro ONES_COUNT_EARLY_EXIT_EN ends RUN as soon as no set bits remain.
module ones_count_ctrl
    import ones_count_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             busy
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  sreg;
    logic [WIDTH-1:0]  shifted;
    logic [CW-1:0]     acc;
    logic [BCW-1:0]    bcnt;
    logic [3:0]        byte_ones;
    logic              load;
    logic              run_last;

    serial1s u_serial1s (
        .din   (sreg[BYTE_W-1:0]),
        .count (byte_ones)
    );

    assign shifted = sreg >> BYTE_W;

`ifdef ONES_COUNT_EARLY_EXIT_EN
    assign run_last = (bcnt == LAST_BYTE) || (shifted == '0);
`else
    assign run_last = (bcnt == LAST_BYTE);
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            acc  <= '0;
            bcnt <= '0;
        end else if (load) begin
            sreg <= din;
            acc  <= '0;
            bcnt <= '0;
        end else if (state_q == RUN) begin
            sreg <= shifted;
            acc  <= acc + CW'(byte_ones);
            bcnt <= bcnt + BCW'(1);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign count = acc;

endmodule
